// File: rtl/state_sequencer_pkg.sv
// riscpkg: shared encodings for the multicycle 16-bit RISC core.
//   - Opcode and CZ-field encodings decoded from the instruction register.
//   - StateID constants used by both the next-state engine and the
//     negedge control-signal controller, so there is one encoding only.
//   - Small helpers for building the dispatch key and spotting the last
//     state of an instruction.
package riscpkg;

  // Width of the StateID encoding itself. The sequencer port may be wider.
  localparam int SID_W = 6;

  // Opcodes, ir[15:12]
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  // CZ condition field, ir[1:0]
  typedef enum logic [1:0] {
    CZ_NONE = 2'b00,  // unconditional
    CZ_Z    = 2'b01,  // write only if Z set
    CZ_C    = 2'b10,  // write only if C set
    CZ_BOTH = 2'b11   // reserved: no write, straight to PC increment
  } cz_e;

  // Fields of the instruction the dispatcher looks at
  typedef struct packed {
    logic [3:0] opcode;
    cz_e        cz;
  } dispatch_key_t;

  // StateID constants
  localparam logic [SID_W-1:0] S_FETCH     = 6'd0;
  localparam logic [SID_W-1:0] S_ADD_EXEC  = 6'd1;
  localparam logic [SID_W-1:0] S_ADD_WB    = 6'd2;
  localparam logic [SID_W-1:0] S_ADI_EXEC  = 6'd3;
  localparam logic [SID_W-1:0] S_ADI_WB    = 6'd4;
  localparam logic [SID_W-1:0] S_ADC_WB    = 6'd5;
  localparam logic [SID_W-1:0] S_ADZ_WB    = 6'd6;
  localparam logic [SID_W-1:0] S_ILLEGAL   = 6'd7;
  localparam logic [SID_W-1:0] S_NDU_EXEC  = 6'd8;
  localparam logic [SID_W-1:0] S_NDU_WB    = 6'd9;
  localparam logic [SID_W-1:0] S_NDU_CZ_WB = 6'd10;
  localparam logic [SID_W-1:0] S_LHI_EXEC  = 6'd11;
  localparam logic [SID_W-1:0] S_LHI_WB    = 6'd12;
  localparam logic [SID_W-1:0] S_PC_INC    = 6'd13;
  localparam logic [SID_W-1:0] S_PC_WB     = 6'd14;
  localparam logic [SID_W-1:0] S_MEM_ADDR  = 6'd15;
  localparam logic [SID_W-1:0] S_SW_DATA   = 6'd16;
  localparam logic [SID_W-1:0] S_SW_WAIT   = 6'd17;
  localparam logic [SID_W-1:0] S_LW_WAIT   = 6'd18;
  localparam logic [SID_W-1:0] S_LW_WB     = 6'd19;
  localparam logic [SID_W-1:0] S_BEQ_READ  = 6'd22;
  localparam logic [SID_W-1:0] S_BEQ_CMP   = 6'd23;
  localparam logic [SID_W-1:0] S_BEQ_TGT   = 6'd24;
  localparam logic [SID_W-1:0] S_BEQ_LOAD  = 6'd25;
  localparam logic [SID_W-1:0] S_JAL_LINK  = 6'd26;
  localparam logic [SID_W-1:0] S_JAL_JUMP  = 6'd27;
  localparam logic [SID_W-1:0] S_JLR_LINK  = 6'd28;
  localparam logic [SID_W-1:0] S_JLR_JUMP  = 6'd29;
  localparam logic [SID_W-1:0] S_LM_ADDR   = 6'd30;
  localparam logic [SID_W-1:0] S_LM_READ   = 6'd31;
  localparam logic [SID_W-1:0] S_LM_WB     = 6'd32;
  localparam logic [SID_W-1:0] S_LM_NEXT   = 6'd33;
  localparam logic [SID_W-1:0] S_SM_ADDR   = 6'd34;
  localparam logic [SID_W-1:0] S_SM_READ   = 6'd35;
  localparam logic [SID_W-1:0] S_SM_WRITE  = 6'd36;
  localparam logic [SID_W-1:0] S_SM_NEXT   = 6'd37;

  // Build the dispatch key from an instruction word
  function automatic dispatch_key_t make_key(input logic [15:0] instr);
    dispatch_key_t k;
    k.opcode = instr[15:12];
    k.cz     = cz_e'(instr[1:0]);
    return k;
  endfunction

  // States whose return to fetch marks a completed instruction
  function automatic logic is_final_state(input logic [SID_W-1:0] s);
    return (s == S_PC_WB) || (s == S_BEQ_LOAD) ||
           (s == S_JAL_JUMP) || (s == S_JLR_JUMP);
  endfunction

endpackage

// File: rtl/state_sequencer_if.sv
// state_sequencer_if: bundle between the core datapath and the sequencer.
//   Core -> sequencer : ir, compare, carry_flag, zero_flag, mem_ready
//   Sequencer -> core : state_id, loop_cnt, loop_last, instr_done, illegal
// master = core/datapath side, slave = sequencer side.
interface state_sequencer_if #(
  parameter int STATE_W = 6
);
  logic [15:0]        ir;
  logic               compare;
  logic               carry_flag;
  logic               zero_flag;
  logic               mem_ready;
  logic [STATE_W-1:0] state_id;
  logic [2:0]         loop_cnt;
  logic               loop_last;
  logic               instr_done;
  logic               illegal;

  modport master (
    output ir, compare, carry_flag, zero_flag, mem_ready,
    input  state_id, loop_cnt, loop_last, instr_done, illegal
  );

  modport slave (
    input  ir, compare, carry_flag, zero_flag, mem_ready,
    output state_id, loop_cnt, loop_last, instr_done, illegal
  );
endinterface

// File: rtl/state_sequencer_dispatch.sv
// seq_dispatch: purely combinational instruction decode for the sequencer.
//   i_key        : {opcode, CZ} taken from the instruction register
//   o_fetch_next : successor of S0 (fetch)
//   o_add_next   : successor of S1 (ADD execute), selected by CZ
//   o_ndu_next   : successor of S8 (NDU execute), selected by CZ
module seq_dispatch
  import riscpkg::*;
(
  input  dispatch_key_t    i_key,
  output logic [SID_W-1:0] o_fetch_next,
  output logic [SID_W-1:0] o_add_next,
  output logic [SID_W-1:0] o_ndu_next
);

  always_comb begin
    o_fetch_next = S_ILLEGAL;
    case (i_key.opcode)
      OP_ADD:        o_fetch_next = S_ADD_EXEC;
      OP_ADI:        o_fetch_next = S_ADI_EXEC;
      OP_NDU:        o_fetch_next = S_NDU_EXEC;
      OP_LHI:        o_fetch_next = S_LHI_EXEC;
      OP_LW, OP_SW:  o_fetch_next = S_MEM_ADDR;  // split later on ir[12]
      OP_LM:         o_fetch_next = S_LM_ADDR;
      OP_SM:         o_fetch_next = S_SM_ADDR;
      OP_JAL:        o_fetch_next = S_JAL_LINK;
      OP_JLR:        o_fetch_next = S_JLR_LINK;
      OP_BEQ:        o_fetch_next = S_BEQ_READ;
      default:       o_fetch_next = S_ILLEGAL;
    endcase
  end

  // The flag test itself happens in the datapath; here CZ only picks which
  // write-back state the controller should see.
  always_comb begin
    o_add_next = S_PC_INC;
    case (i_key.cz)
      CZ_NONE: o_add_next = S_ADD_WB;
      CZ_C:    o_add_next = S_ADC_WB;
      CZ_Z:    o_add_next = S_ADZ_WB;
      default: o_add_next = S_PC_INC;
    endcase
  end

  always_comb begin
    o_ndu_next = S_PC_INC;
    case (i_key.cz)
      CZ_NONE:    o_ndu_next = S_NDU_WB;
      CZ_C, CZ_Z: o_ndu_next = S_NDU_CZ_WB;
      default:    o_ndu_next = S_PC_INC;
    endcase
  end

endmodule

// File: rtl/state_sequencer.sv
// state_sequencer: next-state engine for the multicycle 16-bit RISC core.
// Updates on posedge clk so state_id is stable when the control-signal
// controller samples it on the negedge.
//   clk  : system clock
//   rst  : synchronous reset, active-low
//   bus  : slave side of state_sequencer_if
//          in : ir, compare, carry_flag, zero_flag, mem_ready
//          out: state_id (registered), loop_cnt (registered),
//               loop_last (combinational), instr_done, illegal (registered)
// LOOP_N is the LM/SM register-list length; a power of two, at most 8.
module state_sequencer
  import riscpkg::*;
#(
  parameter int STATE_W = 6,
  parameter int LOOP_N  = 8
) (
  input  logic             clk,
  input  logic             rst,
  state_sequencer_if.slave bus
);

  localparam logic [2:0] LOOP_LAST = 3'(LOOP_N - 1);

  logic [SID_W-1:0] r_state;
  logic [2:0]       r_loop_cnt;
  logic             r_instr_done;
  logic             r_illegal;

  logic [SID_W-1:0] w_state_next;
  logic [2:0]       w_loop_cnt_next;
  logic [SID_W-1:0] w_fetch_next;
  logic [SID_W-1:0] w_add_next;
  logic [SID_W-1:0] w_ndu_next;
  logic             w_loop_last;
  logic             w_is_store;
  dispatch_key_t    w_key;

  // Flags and the register fields of ir are consumed by the datapath only.
  logic             w_unused_inputs;
  assign w_unused_inputs = ^{bus.ir[11:2], bus.carry_flag, bus.zero_flag};

  assign w_key       = make_key(bus.ir);
  assign w_is_store  = bus.ir[12];  // LW=0100, SW=0101
  assign w_loop_last = (r_loop_cnt == LOOP_LAST);

  seq_dispatch u_dispatch (
    .i_key        (w_key),
    .o_fetch_next (w_fetch_next),
    .o_add_next   (w_add_next),
    .o_ndu_next   (w_ndu_next)
  );

  always_comb begin
    w_state_next    = S_FETCH;  // unknown encodings recover to fetch
    w_loop_cnt_next = r_loop_cnt;
    case (r_state)
      S_FETCH: begin
        w_state_next    = w_fetch_next;
        w_loop_cnt_next = 3'd0;
      end
      // ADD family
      S_ADD_EXEC:                       w_state_next = w_add_next;
      S_ADD_WB, S_ADC_WB, S_ADZ_WB:     w_state_next = S_PC_INC;
      // ADI / LHI
      S_ADI_EXEC:                       w_state_next = S_ADI_WB;
      S_ADI_WB:                         w_state_next = S_PC_INC;
      S_LHI_EXEC:                       w_state_next = S_LHI_WB;
      S_LHI_WB:                         w_state_next = S_PC_INC;
      // NDU family
      S_NDU_EXEC:                       w_state_next = w_ndu_next;
      S_NDU_WB, S_NDU_CZ_WB:            w_state_next = S_PC_INC;
      S_ILLEGAL:                        w_state_next = S_PC_INC;
      // PC increment tail shared by most instructions
      S_PC_INC:                         w_state_next = S_PC_WB;
      S_PC_WB:                          w_state_next = S_FETCH;
      // LW / SW
      S_MEM_ADDR: w_state_next = w_is_store ? S_SW_DATA : S_LW_WAIT;
      S_SW_DATA:  w_state_next = S_SW_WAIT;
      S_SW_WAIT:  w_state_next = bus.mem_ready ? S_PC_INC : S_SW_WAIT;
      S_LW_WAIT:  w_state_next = bus.mem_ready ? S_LW_WB : S_LW_WAIT;
      S_LW_WB:    w_state_next = S_PC_INC;
      // BEQ: taken path has already loaded the target, so no PC increment
      S_BEQ_READ: w_state_next = S_BEQ_CMP;
      S_BEQ_CMP:  w_state_next = bus.compare ? S_BEQ_TGT : S_PC_INC;
      S_BEQ_TGT:  w_state_next = S_BEQ_LOAD;
      S_BEQ_LOAD: w_state_next = S_FETCH;
      // Jumps
      S_JAL_LINK: w_state_next = S_JAL_JUMP;
      S_JAL_JUMP: w_state_next = S_FETCH;
      S_JLR_LINK: w_state_next = S_JLR_JUMP;
      S_JLR_JUMP: w_state_next = S_FETCH;
      // LM loop: exit decision uses loop_last from before the increment
      S_LM_ADDR:  w_state_next = S_LM_READ;
      S_LM_READ:  w_state_next = S_LM_WB;
      S_LM_WB:    w_state_next = S_LM_NEXT;
      S_LM_NEXT: begin
        w_loop_cnt_next = r_loop_cnt + 3'd1;
        w_state_next    = w_loop_last ? S_PC_INC : S_LM_ADDR;
      end
      // SM loop, same shape as LM
      S_SM_ADDR:  w_state_next = S_SM_READ;
      S_SM_READ:  w_state_next = S_SM_WRITE;
      S_SM_WRITE: w_state_next = S_SM_NEXT;
      S_SM_NEXT: begin
        w_loop_cnt_next = r_loop_cnt + 3'd1;
        w_state_next    = w_loop_last ? S_PC_INC : S_SM_ADDR;
      end
      default:    w_state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_FETCH;
      r_loop_cnt   <= 3'd0;
      r_instr_done <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_loop_cnt   <= w_loop_cnt_next;
      // Registered so the flag lines up with the fetch cycle it announces
      r_instr_done <= (w_state_next == S_FETCH) && is_final_state(r_state);
      r_illegal    <= (w_state_next == S_ILLEGAL);
    end
  end

  assign bus.state_id   = STATE_W'(r_state);
  assign bus.loop_cnt   = r_loop_cnt;
  assign bus.loop_last  = w_loop_last;
  assign bus.instr_done = r_instr_done;
  assign bus.illegal    = r_illegal;

endmodule

// File: tb/tb_state_sequencer.sv
module tb_state_sequencer;
  import riscpkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  state_sequencer_if #(.STATE_W(6)) sif ();

  state_sequencer #(.STATE_W(6), .LOOP_N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] st;
    logic [2:0] lc;
    logic       done;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   wait_left = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic push(input int st, input int lc, input bit done);
    exp_t e;
    e.st   = 6'(st);
    e.lc   = 3'(lc);
    e.done = done;
    e.ill  = (st == 7);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model reacts to the current state, then one clock, then pop.
  task automatic advance(output exp_t e);
    if (sif.state_id == 6'd17 || sif.state_id == 6'd18) begin
      if (wait_left > 0) begin
        sif.mem_ready = 1'b0;
        wait_left--;
      end else begin
        sif.mem_ready = 1'b1;
      end
    end else begin
      sif.mem_ready = 1'b0;
    end
    sif.carry_flag = 1'($urandom);
    sif.zero_flag  = 1'($urandom);
    tick();
    e = exp_q.pop_front();
  endtask

  function automatic string obs_str();
    return $sformatf("state=%0d cnt=%0d last=%b done=%b ill=%b", sif.state_id,
                     sif.loop_cnt, sif.loop_last, sif.instr_done, sif.illegal);
  endfunction

  function automatic string exp_str(input exp_t e);
    return $sformatf("state=%0d cnt=%0d last=%b done=%b ill=%b", e.st, e.lc,
                     (e.lc == 3'd7), e.done, e.ill);
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    tick();
    tick();
    e.st = 6'd0; e.lc = 3'd0; e.done = 1'b0; e.ill = 1'b0;
    checks++;
    if ({sif.state_id, sif.loop_cnt, sif.instr_done, sif.illegal} !== {e.st, e.lc, e.done, e.ill}) begin
      errors++;
      $display("FAIL reset: got %s, expected %s", obs_str(), exp_str(e));
    end
    rst = 1'b1;
    $display("txn reset -> state %0d", sif.state_id);
  endtask

  // ADD/ADC/ADZ/ADD-11, NDU variants, ADI, LHI: first state, optional middle
  task automatic test_alu();
    logic [15:0] irs [10] = '{16'h0000, 16'h0002, 16'h0001, 16'h0003,
                             16'h2000, 16'h2002, 16'h2001, 16'h2003,
                             16'h1000, 16'h3000};
    int first [10] = '{1, 1, 1, 1, 8, 8, 8, 8, 3, 11};
    int mid   [10] = '{2, 5, 6, 0, 9, 10, 10, 0, 4, 12};
    exp_t e;
    int n;
    for (int i = 0; i < 10; i++) begin
      sif.ir = irs[i];
      push(first[i], 0, 0);
      if (mid[i] != 0) push(mid[i], 0, 0);
      push(13, 0, 0); push(14, 0, 0); push(0, 0, 1);
      n = 1;
      while (exp_q.size() > 0) begin
        advance(e);
        n++;
        checks++;
        if ({sif.state_id, sif.loop_cnt, sif.loop_last, sif.instr_done, sif.illegal} !==
            {e.st, e.lc, (e.lc == 3'd7), e.done, e.ill}) begin
          errors++;
          $display("FAIL alu ir=%h: got %s, expected %s", irs[i], obs_str(), exp_str(e));
        end
      end
      $display("txn alu ir=%h cycles=%0d", irs[i], n - 1);
    end
  endtask

  task automatic test_beq();
    exp_t e;
    for (int t = 1; t >= 0; t--) begin
      sif.ir = 16'hC000;
      sif.compare = 1'(t);
      push(22, 0, 0); push(23, 0, 0);
      if (t == 1) begin
        push(24, 0, 0); push(25, 0, 0);
      end else begin
        push(13, 0, 0); push(14, 0, 0);
      end
      push(0, 0, 1);
      while (exp_q.size() > 0) begin
        advance(e);
        checks++;
        if ({sif.state_id, sif.loop_cnt, sif.loop_last, sif.instr_done, sif.illegal} !==
            {e.st, e.lc, (e.lc == 3'd7), e.done, e.ill}) begin
          errors++;
          $display("FAIL beq compare=%0d: got %s, expected %s", t, obs_str(), exp_str(e));
        end
      end
      $display("txn beq compare=%0d", t);
    end
    sif.compare = 1'b0;
  endtask

  // JAL, JLR, JAL issued with no gap; ir is swapped as each fetch is seen
  task automatic test_back_to_back();
    logic [15:0] ir_q[$] = '{16'h9000, 16'h8000};
    exp_t e;
    sif.ir = 16'h8000;
    push(26, 0, 0); push(27, 0, 0); push(0, 0, 1);
    push(28, 0, 0); push(29, 0, 0); push(0, 0, 1);
    push(26, 0, 0); push(27, 0, 0); push(0, 0, 1);
    while (exp_q.size() > 0) begin
      advance(e);
      checks++;
      if ({sif.state_id, sif.loop_cnt, sif.loop_last, sif.instr_done, sif.illegal} !==
          {e.st, e.lc, (e.lc == 3'd7), e.done, e.ill}) begin
        errors++;
        $display("FAIL back_to_back ir=%h: got %s, expected %s", sif.ir, obs_str(), exp_str(e));
      end
      if (e.st == 6'd0) begin
        $display("txn jump ir=%h", sif.ir);
        if (ir_q.size() > 0) sif.ir = ir_q.pop_front();
      end
    end
  endtask

  task automatic test_mem();
    logic [15:0] irs [3] = '{16'h4000, 16'h5000, 16'h4000};
    int waits [3] = '{3, 2, 0};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      sif.ir = irs[i];
      wait_left = waits[i];
      push(15, 0, 0);
      if (irs[i][12]) begin
        push(16, 0, 0);
        for (int k = 0; k <= waits[i]; k++) push(17, 0, 0);
      end else begin
        for (int k = 0; k <= waits[i]; k++) push(18, 0, 0);
        push(19, 0, 0);
      end
      push(13, 0, 0); push(14, 0, 0); push(0, 0, 1);
      while (exp_q.size() > 0) begin
        advance(e);
        checks++;
        if ({sif.state_id, sif.loop_cnt, sif.loop_last, sif.instr_done, sif.illegal} !==
            {e.st, e.lc, (e.lc == 3'd7), e.done, e.ill}) begin
          errors++;
          $display("FAIL mem ir=%h wait=%0d: got %s, expected %s", irs[i], waits[i], obs_str(), exp_str(e));
        end
      end
      $display("txn mem ir=%h wait=%0d", irs[i], waits[i]);
    end
  endtask

  task automatic test_loop();
    logic [15:0] irs [2] = '{16'h60FF, 16'h70FF};
    int base [2] = '{30, 34};
    exp_t e;
    int n;
    for (int i = 0; i < 2; i++) begin
      sif.ir = irs[i];
      for (int p = 0; p < 8; p++)
        for (int s = 0; s < 4; s++) push(base[i] + s, p, 0);
      push(13, 0, 0); push(14, 0, 0); push(0, 0, 1);
      n = 1;
      while (exp_q.size() > 0) begin
        advance(e);
        if (e.st != 6'd0) n++;
        checks++;
        if ({sif.state_id, sif.loop_cnt, sif.loop_last, sif.instr_done, sif.illegal} !==
            {e.st, e.lc, (e.lc == 3'd7), e.done, e.ill}) begin
          errors++;
          $display("FAIL loop ir=%h: got %s, expected %s", irs[i], obs_str(), exp_str(e));
        end
      end
      checks++;
      if (n !== 35) begin
        errors++;
        $display("FAIL loop_latency ir=%h: got %0d cycles, expected 35", irs[i], n);
      end
      $display("txn loop ir=%h cycles=%0d", irs[i], n);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] irs [5] = '{16'hF000, 16'hA000, 16'hB000, 16'hD000, 16'hE123};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      sif.ir = irs[i];
      push(7, 0, 0); push(13, 0, 0); push(14, 0, 0); push(0, 0, 1);
      while (exp_q.size() > 0) begin
        advance(e);
        checks++;
        if ({sif.state_id, sif.loop_cnt, sif.loop_last, sif.instr_done, sif.illegal} !==
            {e.st, e.lc, (e.lc == 3'd7), e.done, e.ill}) begin
          errors++;
          $display("FAIL illegal ir=%h: got %s, expected %s", irs[i], obs_str(), exp_str(e));
        end
      end
      $display("txn illegal ir=%h", irs[i]);
    end
  endtask

  // Reset in S19 of LW, mid LM loop, and in S14 where instr_done would rise
  task automatic test_reset_mid();
    logic [15:0] irs [3] = '{16'h4000, 16'h60FF, 16'h0000};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      sif.ir = irs[i];
      wait_left = 0;
      if (i == 0) begin
        push(15, 0, 0); push(18, 0, 0); push(19, 0, 0);
      end else if (i == 1) begin
        for (int p = 0; p < 2; p++)
          for (int s = 0; s < 4; s++) push(30 + s, p, 0);
        push(30, 2, 0);
      end else begin
        push(1, 0, 0); push(2, 0, 0); push(13, 0, 0); push(14, 0, 0);
      end
      while (exp_q.size() > 0) begin
        advance(e);
        checks++;
        if ({sif.state_id, sif.loop_cnt, sif.loop_last, sif.instr_done, sif.illegal} !==
            {e.st, e.lc, (e.lc == 3'd7), e.done, e.ill}) begin
          errors++;
          $display("FAIL reset_mid_pre ir=%h: got %s, expected %s", irs[i], obs_str(), exp_str(e));
        end
      end
      rst = 1'b0;
      push(0, 0, 0);
      advance(e);
      rst = 1'b1;
      checks++;
      if ({sif.state_id, sif.loop_cnt, sif.loop_last, sif.instr_done, sif.illegal} !==
          {e.st, e.lc, (e.lc == 3'd7), e.done, e.ill}) begin
        errors++;
        $display("FAIL reset_mid ir=%h: got %s, expected %s", irs[i], obs_str(), exp_str(e));
      end
      $display("txn reset_mid ir=%h", irs[i]);
    end
  endtask

  // Corrupt the state register to an unused encoding while in S1
  task automatic test_unlisted();
    exp_t e;
    sif.ir = 16'h0000;
    push(1, 0, 0);
    advance(e);
    checks++;
    if (sif.state_id !== e.st) begin
      errors++;
      $display("FAIL unlisted_pre: got %s, expected %s", obs_str(), exp_str(e));
    end
    force dut.r_state = 6'd50;
    #1;
    release dut.r_state;
    push(0, 0, 0);
    advance(e);
    checks++;
    if ({sif.state_id, sif.loop_cnt, sif.loop_last, sif.instr_done, sif.illegal} !==
        {e.st, e.lc, (e.lc == 3'd7), e.done, e.ill}) begin
      errors++;
      $display("FAIL unlisted: got %s, expected %s", obs_str(), exp_str(e));
    end
    $display("txn unlisted state 50 -> %0d", sif.state_id);
  endtask

  initial begin
    sif.ir         = 16'h0000;
    sif.compare    = 1'b0;
    sif.carry_flag = 1'b0;
    sif.zero_flag  = 1'b0;
    sif.mem_ready  = 1'b0;
    test_reset();
    test_alu();
    test_beq();
    test_back_to_back();
    test_mem();
    test_loop();
    test_illegal();
    test_reset_mid();
    test_unlisted();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
